// File: rtl/acog_mem_px_pkg.sv
// Shared types and SPR window layout for the cog register file.
package acog_mem_px_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  localparam int SPR_WINDOW  = 16;
  localparam int SPR_PAR     = 0;
  localparam int SPR_CNT     = 1;
  localparam int SPR_IN_BASE = 2;

  // OUT and DIR banks follow the IN bank, so their offsets scale with the port count.
  function automatic int spr_out_base(input int nports);
    return SPR_IN_BASE + nports;
  endfunction

  function automatic int spr_dir_base(input int nports);
    return SPR_IN_BASE + 2 * nports;
  endfunction

  function automatic int spr_used(input int nports);
    return SPR_IN_BASE + 3 * nports;
  endfunction

endpackage

// File: rtl/acog_ram_1r1w.sv
// Memory array with one clocked write port and one asynchronous read port.
// The owning block registers the read data.
module acog_ram_1r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic              clk_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/acog_mem_px.sv
// Cog register file: three read ports, one write port, SPR overlay and hub loader.
// All operand outputs are registered, with same-cycle write bypass.
module acog_mem_px
  import acog_mem_px_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 9,
  parameter int NPORTS     = 2,
  parameter int LOAD_WORDS = 496,
  parameter int SPR_BASE   = 2**ADDR_W - 16
) (
  input  logic                     clk_in,
  input  logic                     reset_n_in,
  input  logic [ADDR_W-1:0]        f_addr_in,
  output logic [DATA_W-1:0]        f_data_o,
  input  logic [ADDR_W-1:0]        s_addr_in,
  input  logic                     s_imm_in,
  output logic [DATA_W-1:0]        s_data_o,
  output logic [DATA_W-1:0]        s_neg_o,
  input  logic [ADDR_W-1:0]        d_addr_in,
  output logic [DATA_W-1:0]        d_data_o,
  output logic                     d_zero_o,
  input  logic                     w_en_in,
  input  logic [ADDR_W-1:0]        w_addr_in,
  input  logic [DATA_W-1:0]        w_data_in,
  input  logic [DATA_W-1:0]        cnt_in,
  input  logic [DATA_W-1:0]        par_in,
  input  logic                     load_start_in,
  input  logic                     ld_valid_in,
  input  logic [DATA_W-1:0]        ld_data_in,
  output logic                     ld_ready_o,
  output logic                     run_mode_o,
  input  logic [NPORTS*DATA_W-1:0] pin_in,
  output logic [NPORTS*DATA_W-1:0] pin_out_o,
  output logic [NPORTS*DATA_W-1:0] pin_dir_o
);

  localparam logic [ADDR_W:0]   SPR_LO   = (ADDR_W+1)'(SPR_BASE);
  localparam logic [ADDR_W:0]   SPR_HI   = (ADDR_W+1)'(SPR_BASE + SPR_WINDOW);
  localparam logic [3:0]        OFF_BASE = 4'(SPR_BASE);
  localparam logic [3:0]        OFF_OUT  = 4'(spr_out_base(NPORTS));
  localparam logic [3:0]        OFF_DIR  = 4'(spr_dir_base(NPORTS));
  localparam logic [3:0]        OFF_USED = 4'(spr_used(NPORTS));
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(LOAD_WORDS - 1);

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       ptr_q;
  logic [DATA_W-1:0]       par_q;
  logic [NPORTS*DATA_W-1:0] in_q, out_q, dir_q;
  logic [DATA_W-1:0]       f_q, s_q, sn_q, d_q;
  logic                    dz_q;

  logic                    ld_fire, run, mem_wr, spr_wr;
  logic [3:0]              w_off;
  logic                    ram_we;
  logic [ADDR_W-1:0]       ram_waddr;
  logic [DATA_W-1:0]       ram_wdata;
  logic [DATA_W-1:0]       f_ram, s_ram, d_ram;
  logic [DATA_W-1:0]       f_next, s_next, d_next;

  function automatic logic [3:0] spr_off(input logic [3:0] lo);
    return lo - OFF_BASE;
  endfunction

  function automatic logic spr_mapped(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} >= SPR_LO) && ({1'b0, a} < SPR_HI) && (spr_off(a[3:0]) < OFF_USED);
  endfunction

  function automatic logic spr_outdir(input logic [ADDR_W-1:0] a);
    return spr_mapped(a) && (spr_off(a[3:0]) >= OFF_OUT);
  endfunction

  function automatic logic [DATA_W-1:0] spr_read(input logic [3:0] off);
    logic [DATA_W-1:0] v;
    v = '0;
    if (off == 4'(SPR_PAR)) v = par_q;
    if (off == 4'(SPR_CNT)) v = cnt_in;
    for (int k = 0; k < NPORTS; k++) begin
      if (off == 4'(SPR_IN_BASE + k)) v = in_q[k*DATA_W +: DATA_W];
      if (off == OFF_OUT + 4'(k))     v = out_q[k*DATA_W +: DATA_W];
      if (off == OFF_DIR + 4'(k))     v = dir_q[k*DATA_W +: DATA_W];
    end
    return v;
  endfunction

  assign run     = (state_q == RUN);
  assign ld_fire = (state_q == LOAD) && ld_valid_in;
  assign w_off   = spr_off(w_addr_in[3:0]);
  assign mem_wr  = run && w_en_in && !spr_mapped(w_addr_in);
  assign spr_wr  = run && w_en_in && spr_outdir(w_addr_in);

  // The loader owns the shared write port while loading; otherwise the pipeline does.
  assign ram_we    = ld_fire || mem_wr;
  assign ram_waddr = ld_fire ? ptr_q : w_addr_in;
  assign ram_wdata = ld_fire ? ld_data_in : w_data_in;

  acog_ram_1r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram_f (
    .clk_in(clk_in), .wr_en(ram_we), .wr_addr(ram_waddr), .wr_data(ram_wdata),
    .rd_addr(f_addr_in), .rd_data(f_ram)
  );

  acog_ram_1r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram_s (
    .clk_in(clk_in), .wr_en(ram_we), .wr_addr(ram_waddr), .wr_data(ram_wdata),
    .rd_addr(s_addr_in), .rd_data(s_ram)
  );

  acog_ram_1r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram_d (
    .clk_in(clk_in), .wr_en(ram_we), .wr_addr(ram_waddr), .wr_data(ram_wdata),
    .rd_addr(d_addr_in), .rd_data(d_ram)
  );

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_start_in) state_d = LOAD;
      LOAD:    if (ld_fire && (ptr_q == LAST_PTR)) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      ptr_q <= '0;
      par_q <= '0;
      in_q  <= '0;
      out_q <= '0;
      dir_q <= '0;
    end else begin
      in_q <= pin_in;
      if ((state_q == IDLE) && load_start_in) begin
        ptr_q <= '0;
        par_q <= par_in;
      end else if (ld_fire) begin
        ptr_q <= ptr_q + 1'b1;
      end
      for (int k = 0; k < NPORTS; k++) begin
        if (spr_wr && (w_off == OFF_OUT + 4'(k))) out_q[k*DATA_W +: DATA_W] <= w_data_in;
        if (spr_wr && (w_off == OFF_DIR + 4'(k))) dir_q[k*DATA_W +: DATA_W] <= w_data_in;
      end
    end
  end

  // SPR reads only apply in RUN; SPR bypass only for OUT/DIR since other SPR writes are dropped.
  always_comb begin
    f_next = f_ram;
    s_next = s_ram;
    d_next = d_ram;
    if (mem_wr && (f_addr_in == w_addr_in)) f_next = w_data_in;

    if (s_imm_in) begin
      s_next = DATA_W'(s_addr_in);
    end else if (run && spr_mapped(s_addr_in)) begin
      s_next = (spr_wr && (s_addr_in == w_addr_in)) ? w_data_in : spr_read(spr_off(s_addr_in[3:0]));
    end else if (mem_wr && (s_addr_in == w_addr_in)) begin
      s_next = w_data_in;
    end

    if (run && spr_mapped(d_addr_in)) begin
      d_next = (spr_wr && (d_addr_in == w_addr_in)) ? w_data_in : spr_read(spr_off(d_addr_in[3:0]));
    end else if (mem_wr && (d_addr_in == w_addr_in)) begin
      d_next = w_data_in;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      f_q  <= '0;
      s_q  <= '0;
      sn_q <= '0;
      d_q  <= '0;
      dz_q <= 1'b0;
    end else begin
      f_q  <= f_next;
      s_q  <= s_next;
      sn_q <= '0 - s_next;
      d_q  <= d_next;
      dz_q <= (d_next == '0);
    end
  end

  assign f_data_o   = f_q;
  assign s_data_o   = s_q;
  assign s_neg_o    = sn_q;
  assign d_data_o   = d_q;
  assign d_zero_o   = dz_q;
  assign ld_ready_o = (state_q == LOAD);
  assign run_mode_o = run;
  assign pin_out_o  = out_q;
  assign pin_dir_o  = dir_q;

endmodule
